btb_predictor: RTL and testbench
================================

// Module: btb_predictor
// PURPOSE
//  Parametrised branch target buffer with per-entry saturating direction counters.
//  Supplies the fetch-stage next-PC prediction: the PCSRC_BTB path of the 16-bit pipeline.
//  Trains from branch/jump resolution in ID, including the flush cases (BR/NBR/JMP/JR).
//  Adds a global invalidate and saturating performance counters; the single-bit, fixed-depth predecessor had neither.
// PARAMETERS
//  WORD_SIZE  16  data/address width
//  IDX_BITS   4   index bits; entries = 2**IDX_BITS; tag = pc[WORD_SIZE-1:IDX_BITS]
//  CNT_BITS   2   direction counter width (>=1); predict taken when counter MSB = 1
//  PERF_BITS  16  width of each performance counter
// PORTS
//  clk           in   1          rising-edge clock
//  reset_n       in   1          synchronous active-low reset
//  pc            in   WORD_SIZE  current fetch PC
//  pred_pc       out  WORD_SIZE  predicted next PC
//  pred_hit      out  1          1 = predicted taken with a valid target
//  upd_valid     in   1          resolution strobe from ID (one instruction per cycle)
//  upd_pc        in   WORD_SIZE  PC of the resolved branch/jump
//  upd_taken     in   1          actual direction
//  upd_is_jump   in   1          unconditional (JMP/JAL/JPR/JRL)
//  upd_target    in   WORD_SIZE  actual target, meaningful when upd_taken = 1
//  upd_mispred   in   1          ID flagged a flush (flush_code != NICE_PRED)
//  inv_all       in   1          invalidate every entry
//  perf_upd      out  PERF_BITS  number of accepted updates
//  perf_mispred  out  PERF_BITS  number of updates with upd_mispred = 1
// BEHAVIOUR
//  Reset (reset_n = 0 at posedge):
//   - all valid bits 0; every counter = WNT = 2**(CNT_BITS-1)-1; tags and targets 0.
//   - perf_upd = perf_mispred = 0.
//   - while reset_n = 0: pred_hit = 0, pred_pc = pc+1.
//  Lookup (combinational, zero latency):
//   - i = pc[IDX_BITS-1:0]; hit = valid[i] && tag[i] == pc tag && cnt[i][MSB].
//   - pred_pc = hit ? target[i] : pc+1, computed mod 2**WORD_SIZE (16'hFFFF -> 16'h0000).
//  Update (posedge, upd_valid = 1 and reset_n = 1); j = upd_pc index:
//   - entry match, taken:      cnt = min(cnt+1, MAX); target = upd_target.
//   - entry match, not taken:  cnt = max(cnt-1, 0); target unchanged.
//   - miss, taken:             allocate (replace) j: valid = 1, tag, target,
//                              cnt = WT = 2**(CNT_BITS-1).
//   - miss, not taken:         no state change.
//   - upd_is_jump with upd_taken: cnt = MAX, regardless of hit or miss.
//   - upd_is_jump with !upd_taken: treated as a not-taken conditional.
//  Timing and priority:
//   - Same-cycle read/write: lookup sees pre-edge contents (no bypass).
//     The new value is visible from the next cycle.
//   - inv_all at posedge clears all valid bits; it has priority over a same-cycle update.
//     That update is dropped for the table but is still counted in perf.
//   - Counters and targets are kept on invalidate.
//  Performance counters (posedge):
//   - perf_upd += 1 on each upd_valid.
//   - perf_mispred += 1 on upd_valid && upd_mispred.
//   - Both saturate at all-ones and are cleared only by reset.
//  Reset mid-operation: reset overrides any pending update or invalidate in that cycle.
//  CNT_BITS = 1: WNT = 0, WT = 1, MAX = 1 (last-outcome predictor).
// TESTING
//  1. Reset, then pc = 16'h0010 -> pred_hit = 0, pred_pc = 16'h0011; perf counters 0.
//  2. Update pc 0x0010, taken, target 0x0040 (not jump).
//     Next cycle, pc = 0x0010 -> pred_hit = 1, pred_pc = 0x0040.
//     Then one not-taken update -> cnt = 1, pred_pc = 0x0011.
//  3. Four taken updates on 0x0020 -> cnt = 3; a fifth stays 3.
//     Two not-taken -> cnt = 1, predicts not taken.
//  4. Aliasing: allocate 0x0013 -> 0x0050, then taken update 0x0023 -> 0x0060.
//     pc = 0x0013 -> pred_hit = 0; pc = 0x0023 -> pred_pc = 0x0060.
//  5. pc = 16'hFFFF with empty entry -> pred_pc = 16'h0000.
//     JAL update at 0xFFFF, target 0x0100 -> cnt = 3, pred_pc = 0x0100.
//  6. inv_all together with upd_valid/upd_mispred -> all pred_hit = 0 next cycle; perf_upd +1, perf_mispred +1.
//     With PERF_BITS = 4 and 20 updates -> perf_upd = 4'hF.

Source files
------------

// File: rtl/btb_predictor.sv
// Branch target buffer with per-entry saturating direction counters, global
// invalidate and saturating update/mispredict performance counters.
module btb_predictor #(
    parameter int WORD_SIZE = 16,
    parameter int IDX_BITS  = 4,
    parameter int CNT_BITS  = 2,
    parameter int PERF_BITS = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WORD_SIZE-1:0] pc,
    output logic [WORD_SIZE-1:0] pred_pc,
    output logic                 pred_hit,
    input  logic                 upd_valid,
    input  logic [WORD_SIZE-1:0] upd_pc,
    input  logic                 upd_taken,
    input  logic                 upd_is_jump,
    input  logic [WORD_SIZE-1:0] upd_target,
    input  logic                 upd_mispred,
    input  logic                 inv_all,
    output logic [PERF_BITS-1:0] perf_upd,
    output logic [PERF_BITS-1:0] perf_mispred
);
    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = WORD_SIZE - IDX_BITS;
    localparam logic [CNT_BITS-1:0] CNT_WNT = CNT_BITS'((2 ** (CNT_BITS - 1)) - 1);
    localparam logic [CNT_BITS-1:0] CNT_WT  = CNT_BITS'(2 ** (CNT_BITS - 1));
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    logic [ENTRIES-1:0]   r_valid;
    logic [TAG_W-1:0]     r_tag    [ENTRIES];
    logic [WORD_SIZE-1:0] r_target [ENTRIES];
    logic [CNT_BITS-1:0]  r_cnt    [ENTRIES];
    logic [PERF_BITS-1:0] r_perf_upd;
    logic [PERF_BITS-1:0] r_perf_mis;

    logic [IDX_BITS-1:0]  w_idx;
    logic [TAG_W-1:0]     w_tag;
    logic                 w_hit;
    logic [IDX_BITS-1:0]  w_uidx;
    logic [TAG_W-1:0]     w_utag;
    logic                 w_umatch;
    logic [CNT_BITS-1:0]  w_ucnt;
    logic [CNT_BITS-1:0]  w_cnt_nxt;
    logic                 w_cnt_wr;

    // Lookup reads pre-edge contents; a same-cycle update is not bypassed.
    assign w_idx    = pc[IDX_BITS-1:0];
    assign w_tag    = pc[WORD_SIZE-1:IDX_BITS];
    assign w_hit    = reset_n && r_valid[w_idx] && (r_tag[w_idx] == w_tag)
                      && r_cnt[w_idx][CNT_BITS-1];
    assign pred_hit = w_hit;
    assign pred_pc  = w_hit ? r_target[w_idx] : pc + WORD_SIZE'(1);

    assign w_uidx   = upd_pc[IDX_BITS-1:0];
    assign w_utag   = upd_pc[WORD_SIZE-1:IDX_BITS];
    assign w_umatch = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
    assign w_ucnt   = r_cnt[w_uidx];

    always_comb begin
        w_cnt_nxt = w_ucnt;
        w_cnt_wr  = 1'b0;
        if (upd_taken) begin
            w_cnt_wr = 1'b1;
            if (upd_is_jump)
                w_cnt_nxt = CNT_MAX;
            else if (!w_umatch)
                w_cnt_nxt = CNT_WT;
            else if (w_ucnt != CNT_MAX)
                w_cnt_nxt = w_ucnt + CNT_BITS'(1);
        end else if (w_umatch) begin
            // A not-taken jump trains exactly like a not-taken conditional.
            w_cnt_wr = 1'b1;
            if (w_ucnt != '0)
                w_cnt_nxt = w_ucnt - CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_cnt[i]    <= CNT_WNT;
            end
        end else if (inv_all) begin
            r_valid <= '0;
        end else if (upd_valid) begin
            if (w_cnt_wr)
                r_cnt[w_uidx] <= w_cnt_nxt;
            if (upd_taken) begin
                r_valid[w_uidx]  <= 1'b1;
                r_tag[w_uidx]    <= w_utag;
                r_target[w_uidx] <= upd_target;
            end
        end
    end

    // Perf counters see every accepted update, even one dropped by inv_all.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_perf_upd <= '0;
            r_perf_mis <= '0;
        end else if (upd_valid) begin
            if (r_perf_upd != '1)
                r_perf_upd <= r_perf_upd + PERF_BITS'(1);
            if (upd_mispred && (r_perf_mis != '1))
                r_perf_mis <= r_perf_mis + PERF_BITS'(1);
        end
    end

    assign perf_upd     = r_perf_upd;
    assign perf_mispred = r_perf_mis;
endmodule

// File: tb/tb_btb_predictor.sv
// Randomized and directed bench for btb_predictor against a table-level model;
// a second instance with 4-bit perf counters exercises saturation.
module tb_btb_predictor;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] pc, upd_pc, upd_target;
    logic        upd_valid, upd_taken, upd_is_jump, upd_mispred, inv_all;
    logic [15:0] pred_pc, pred_pc4, perf_upd, perf_mispred;
    logic        pred_hit, pred_hit4;
    logic [3:0]  perf_upd4, perf_mis4;

    int n_chk = 0;
    int n_pass = 0;

    bit m_valid [16];
    int m_tag   [16];
    int m_tgt   [16];
    int m_cnt   [16];
    int m_pu, m_pm;

    always #5 clk = ~clk;

    btb_predictor dut (
        .clk(clk), .reset_n(reset_n), .pc(pc), .pred_pc(pred_pc), .pred_hit(pred_hit),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_is_jump(upd_is_jump), .upd_target(upd_target), .upd_mispred(upd_mispred),
        .inv_all(inv_all), .perf_upd(perf_upd), .perf_mispred(perf_mispred)
    );

    btb_predictor #(.PERF_BITS(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .pc(pc), .pred_pc(pred_pc4), .pred_hit(pred_hit4),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_is_jump(upd_is_jump), .upd_target(upd_target), .upd_mispred(upd_mispred),
        .inv_all(inv_all), .perf_upd(perf_upd4), .perf_mispred(perf_mis4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_cnt[i] = 1;
        end
        m_pu = 0; m_pm = 0;
    endfunction

    // Drive one cycle's inputs and compare combinational outputs with the model.
    task automatic cyc(input logic rst, input logic [15:0] p, input logic uv,
                       input logic [15:0] up, input logic tk, input logic jp,
                       input logic [15:0] tg, input logic mis, input logic inv);
        int idx;
        bit eh;
        int ep;
        reset_n = rst; pc = p; upd_valid = uv; upd_pc = up; upd_taken = tk;
        upd_is_jump = jp; upd_target = tg; upd_mispred = mis; inv_all = inv;
        #1;
        idx = int'(p) % 16;
        eh  = rst && m_valid[idx] && (m_tag[idx] == int'(p) / 16) && (m_cnt[idx] >= 2);
        ep  = eh ? m_tgt[idx] : (int'(p) + 1) % 65536;
        chk("hit",  {31'd0, pred_hit},  {31'd0, eh});
        chk("ppc",  {16'd0, pred_pc},   ep);
        chk("hit4", {31'd0, pred_hit4}, {31'd0, eh});
        chk("ppc4", {16'd0, pred_pc4},  ep);
        chk("pupd", {16'd0, perf_upd},     imin(m_pu, 65535));
        chk("pmis", {16'd0, perf_mispred}, imin(m_pm, 65535));
        chk("pupd4", {28'd0, perf_upd4},   imin(m_pu, 15));
        chk("pmis4", {28'd0, perf_mis4},   imin(m_pm, 15));
    endtask

    task automatic idle(input logic [15:0] p);
        cyc(1'b1, p, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic upd(input logic [15:0] up, input logic tk, input logic jp,
                       input logic [15:0] tg, input logic mis);
        cyc(1'b1, up, 1'b1, up, tk, jp, tg, mis, 1'b0);
    endtask

    // Clock edge: advance the model from the inputs sampled at this edge.
    task automatic tick();
        int j, t;
        bit m;
        @(posedge clk);
        if (!reset_n) model_reset();
        else begin
            if (upd_valid) begin
                m_pu++;
                if (upd_mispred) m_pm++;
            end
            if (inv_all) begin
                for (int i = 0; i < 16; i++) m_valid[i] = 0;
            end else if (upd_valid) begin
                j = int'(upd_pc) % 16;
                t = int'(upd_pc) / 16;
                m = m_valid[j] && (m_tag[j] == t);
                if (upd_taken) begin
                    m_cnt[j] = m ? imin(m_cnt[j] + 1, 3) : 2;
                    if (upd_is_jump) m_cnt[j] = 3;
                    m_valid[j] = 1; m_tag[j] = t; m_tgt[j] = int'(upd_target);
                end else if (m) begin
                    m_cnt[j] = (m_cnt[j] > 0) ? m_cnt[j] - 1 : 0;
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] rp, rt;
        int r;
        model_reset();
        reset_n = 1'b0; pc = 16'h0010; upd_valid = 0; upd_pc = 0; upd_taken = 0;
        upd_is_jump = 0; upd_target = 0; upd_mispred = 0; inv_all = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state
        cyc(1'b0, 16'h0010, 1'b1, 16'h0010, 1'b1, 1'b0, 16'h0040, 1'b1, 1'b0);
        chk("rst_hit", {31'd0, pred_hit}, 32'd0);
        chk("rst_pc",  {16'd0, pred_pc}, 32'h11);
        tick();

        // Allocate, hit, then one not-taken drops below the taken threshold
        upd(16'h0010, 1, 0, 16'h0040, 0); tick();
        idle(16'h0010);
        chk("t2_hit", {31'd0, pred_hit}, 32'd1);
        chk("t2_pc",  {16'd0, pred_pc}, 32'h40);
        tick();
        upd(16'h0010, 0, 0, 16'h0, 1); tick();
        idle(16'h0010);
        chk("t2_nt", {16'd0, pred_pc}, 32'h11);
        tick();

        // Saturation at MAX, then decrement twice
        repeat (5) begin upd(16'h0020, 1, 0, 16'h0080, 0); tick(); end
        upd(16'h0020, 0, 0, 16'h0, 0); tick();
        idle(16'h0020);
        chk("t3_sat", {31'd0, pred_hit}, 32'd1);
        tick();
        upd(16'h0020, 0, 0, 16'h0, 0); tick();
        idle(16'h0020);
        chk("t3_nt", {16'd0, pred_pc}, 32'h21);
        tick();

        // Aliasing replaces the entry
        upd(16'h0013, 1, 0, 16'h0050, 0); tick();
        upd(16'h0023, 1, 0, 16'h0060, 0); tick();
        idle(16'h0013);
        chk("t4_alias", {31'd0, pred_hit}, 32'd0);
        tick();
        idle(16'h0023);
        chk("t4_pc", {16'd0, pred_pc}, 32'h60);
        tick();

        // PC wrap and jump forcing MAX
        idle(16'hFFFF);
        chk("t5_wrap", {16'd0, pred_pc}, 32'h0);
        tick();
        upd(16'hFFFF, 1, 1, 16'h0100, 0); tick();
        upd(16'hFFFF, 0, 1, 16'h0, 1); tick();
        idle(16'hFFFF);
        chk("t5_jmp", {16'd0, pred_pc}, 32'h100);
        tick();

        // Invalidate beats a same-cycle update, which is still counted
        cyc(1'b1, 16'h0023, 1'b1, 16'h0055, 1'b1, 1'b0, 16'h0077, 1'b1, 1'b1); tick();
        idle(16'h0023); chk("t6_inv", {31'd0, pred_hit}, 32'd0); tick();
        idle(16'hFFFF); chk("t6_inv2", {31'd0, pred_hit}, 32'd0); tick();
        idle(16'h0055); chk("t6_drop", {31'd0, pred_hit}, 32'd0); tick();

        // 4-bit perf counters saturate
        repeat (20) begin upd(16'h0030, 0, 0, 16'h0, 1); tick(); end
        idle(16'h0000);
        chk("p4_sat", {28'd0, perf_upd4}, 32'hF);
        chk("p4_mis", {28'd0, perf_mis4}, 32'hF);
        tick();

        // Randomized traffic over a small set of aliasing PCs
        for (int i = 0; i < 400; i++) begin
            r  = $urandom_range(0, 99);
            rp = ($urandom_range(0, 9) == 0) ? (16'hFFF0 | 16'($urandom_range(0, 3)))
                                             : 16'(($urandom_range(0, 3) << 4) | $urandom_range(0, 3));
            rt = 16'($urandom);
            cyc((i == 200) ? 1'b0 : 1'b1,
                ($urandom_range(0, 1) != 0) ? rp : 16'(($urandom_range(0, 3) << 4) | $urandom_range(0, 3)),
                r < 65, rp, $urandom_range(0, 2) != 0, $urandom_range(0, 4) == 0, rt,
                $urandom_range(0, 3) == 0, r >= 97);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
